// File: rtl/adc_pkg.sv
// Shared FSM encoding and frame geometry for the MCP3002 sampler.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } adc_state_e;

  localparam int FRAME_SCK  = 16;
  localparam int CMD_BITS   = 4;
  localparam int NULL_BIT   = 5;
  localparam int FIRST_DATA = 6;
  localparam int LAST_DATA  = 15;
  localparam int ADC_BITS   = 10;

  // start, single-ended, channel select (ODD/SIGN), MSB-first
  function automatic logic [CMD_BITS-1:0] adc_cmd(input logic chan);
    return {1'b1, 1'b1, chan, 1'b1};
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running period counter; emits a registered one-cycle tick once every PERIOD cycles.
module sample_tick_gen #(
  parameter int PERIOD = 5000
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// Paced MCP3002 SPI sampler: one 16-SCK frame per sample tick, 10-bit result with valid strobe.
//   state    | meaning
//   IDLE     | cs_n high, waiting for sample tick
//   CS_SETUP | cs_n low, start bit on din, one half-period before first SCK
//   SHIFT    | 16 SCK periods: command out, null + B9..B0 in
//   CS_HOLD  | sck low, cs_n still low, one half-period
//   DONE     | cs_n high, data_out loaded, data_valid strobe
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int SAMPLE_DIV = 5000,
  parameter int CHANNEL    = 1
) (
  input  logic                sysclk,
  input  logic                rst_n,
  input  logic                adc_dout,
  output logic                adc_cs_n,
  output logic                adc_sck,
  output logic                adc_din,
  output logic [ADC_BITS-1:0] data_out,
  output logic                data_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int            HW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
  localparam int            PW        = $clog2(FRAME_SCK + 1);

  adc_state_e          state, state_nxt;
  logic [HW-1:0]       half_cnt, half_nxt;
  logic [PW-1:0]       period, period_nxt;
  logic                sck_hi, sck_hi_nxt;
  logic [CMD_BITS-1:0] cmd_sr, cmd_nxt;
  logic [ADC_BITS-1:0] data_sr, data_nxt;
  logic [1:0]          dout_sync;
  logic                tick;
  logic                half_tc;

  sample_tick_gen #(.PERIOD(SAMPLE_DIV)) u_tick (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) dout_sync <= 2'b00;
    else        dout_sync <= {dout_sync[0], adc_dout};
  end

  assign half_tc = (half_cnt == '0);

  always_comb begin
    state_nxt  = state;
    half_nxt   = half_cnt;
    period_nxt = period;
    sck_hi_nxt = sck_hi;
    cmd_nxt    = cmd_sr;
    data_nxt   = data_sr;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt  = CS_SETUP;
          half_nxt   = HALF_LOAD;
          period_nxt = '0;
          sck_hi_nxt = 1'b0;
          cmd_nxt    = adc_cmd(CHANNEL != 0);
        end
      end
      CS_SETUP: begin
        if (half_tc) begin
          state_nxt  = SHIFT;
          half_nxt   = HALF_LOAD;
          period_nxt = PW'(1);
          sck_hi_nxt = 1'b0;
        end else begin
          half_nxt = half_cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (!half_tc) begin
          half_nxt = half_cnt - 1'b1;
        end else begin
          half_nxt = HALF_LOAD;
          if (!sck_hi) begin
            sck_hi_nxt = 1'b1;
          end else begin
            // last cycle of the high half: sample the synchronized MISO bit
            if (period == PW'(NULL_BIT))
              data_nxt = '0;
            else if (period >= PW'(FIRST_DATA) && period <= PW'(LAST_DATA))
              data_nxt = {data_sr[ADC_BITS-2:0], dout_sync[1]};
            sck_hi_nxt = 1'b0;
            if (period == PW'(FRAME_SCK)) begin
              state_nxt = CS_HOLD;
            end else begin
              period_nxt = period + 1'b1;
              cmd_nxt    = {cmd_sr[CMD_BITS-2:0], 1'b0};
            end
          end
        end
      end
      CS_HOLD: begin
        if (half_tc) state_nxt = DONE;
        else         half_nxt  = half_cnt - 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SPI pins and status are registered from next-state values so they never glitch
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      half_cnt   <= '0;
      period     <= '0;
      sck_hi     <= 1'b0;
      cmd_sr     <= '0;
      data_sr    <= '0;
      adc_cs_n   <= 1'b1;
      adc_sck    <= 1'b0;
      adc_din    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      half_cnt   <= half_nxt;
      period     <= period_nxt;
      sck_hi     <= sck_hi_nxt;
      cmd_sr     <= cmd_nxt;
      data_sr    <= data_nxt;
      adc_cs_n   <= !(state_nxt inside {CS_SETUP, SHIFT, CS_HOLD});
      adc_sck    <= (state_nxt == SHIFT) && sck_hi_nxt;
      adc_din    <= (state_nxt inside {CS_SETUP, SHIFT}) && cmd_nxt[CMD_BITS-1];
      data_valid <= (state_nxt == DONE);
      busy       <= (state_nxt != IDLE);
      if (state_nxt == DONE) data_out <= data_nxt;
      if (tick && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

Front-end sampler for the audio path: paces conversions at a fixed sample rate, runs one SPI frame per sample against the 10-bit dual-channel ADC (MCP3002 command format), and presents each result as a 10-bit offset-binary word plus a one-cycle valid strobe. Its `data_out`/`data_valid` pair feeds the processor stage's `data_in`/`data_valid` directly. Every value in this document is a decided requirement.

## Interface
- `CLK_DIV`, default 25: sysclk cycles per SCK half-period (25 gives 1 MHz SCK at 50 MHz sysclk); legal range ≥2.
- `SAMPLE_DIV`, default 5000: sysclk cycles per sample period (10 kHz at 50 MHz); ≥ 36*CLK_DIV+2 for overrun-free operation.
- `CHANNEL`, default 1: ADC input channel (0 or 1), sent as the ODD/SIGN command bit.

- `sysclk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `adc_dout` in 1: ADC serial data out (MISO); asynchronous to sysclk.
- `adc_cs_n` out 1: ADC chip select, active-low.
- `adc_sck` out 1: SPI clock, idle low.
- `adc_din` out 1: ADC serial data in (MOSI).
- `data_out` out 10: last conversion result, offset binary.
- `data_valid` out 1: one-cycle strobe; `data_out` is new in this cycle.
- `busy` out 1: high from the cs_n falling edge through the `data_valid` cycle.
- `overrun` out 1: sticky; a sample tick arrived while busy.

## Operation
- Sample tick: a free-running counter of period SAMPLE_DIV. It issues a one-cycle tick on count wrap and runs regardless of FSM state.
- FSM states:
  - IDLE: on tick, go to CS_SETUP.
  - CS_SETUP: cs_n=0, sck=0, din=start bit (1); lasts CLK_DIV cycles.
  - SHIFT: 16 SCK periods. Each period is a low half of CLK_DIV cycles, then a high half of CLK_DIV cycles.
  - CS_HOLD: sck=0, cs_n=0; lasts CLK_DIV cycles.
  - DONE: one cycle; cs_n=1, `data_out` loaded, data_valid=1. Then go to IDLE.
- MOSI sequence for SCK periods 1–4: 1 (start), 1 (single-ended), CHANNEL, 1 (MSB-first). `adc_din` is 0 for periods 5–16.
- `adc_din` changes only at the start of a low half, never while sck is high.
- `adc_dout` passes through a 2-flop synchronizer.
- The synchronized bit is captured in the last sysclk cycle of each high half:
  - period 5: null bit, discarded;
  - periods 6–15: B9..B0, shifted in MSB-first;
  - period 16: ignored.
- A tick outside IDLE is dropped and sets `overrun`. The in-flight frame is unaffected. Only reset clears `overrun`.
- Reset values: adc_cs_n=1, adc_sck=0, adc_din=0, data_out=10'h000, data_valid=0, busy=0, overrun=0, tick counter=0, FSM=IDLE.
- Reset asserted mid-frame: all outputs return to their reset values immediately. The partial result is discarded and `data_valid` is not raised.

## Timing
- Tick in cycle T: adc_cs_n falls at T+1, and busy rises at T+1.
- adc_cs_n stays low for exactly 34*CLK_DIV cycles.
- data_valid is high at T+1+34*CLK_DIV, the same cycle adc_cs_n returns high.
- busy falls in the cycle after data_valid.
- data_out holds its value until the next DONE.
- Exactly 16 adc_sck rising edges per frame, SCK duty cycle 50%.
- Minimum cs_n high time between frames is SAMPLE_DIV − 34*CLK_DIV cycles, which is ≥ 2*CLK_DIV when SAMPLE_DIV is legal.
- First tick after reset release: SAMPLE_DIV cycles later.

## Structure
- Shared package `adc_pkg`:
  - FSM state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE);
  - FRAME_SCK=16, CMD_BITS=4, NULL_BIT=5, FIRST_DATA=6, LAST_DATA=15, ADC_BITS=10.
- Sub-module `sample_tick_gen`: parameterized period counter with async active-low reset and a one-cycle tick output.
- Top contains: synchronizer, FSM, half-period counter, SCK period counter, command shift and data shift registers.

## Test plan
- Bench params: CLK_DIV=2, SAMPLE_DIV=100, CHANNEL=1. ADC model returns 10'h181. Required: MOSI bits 1,1,1,1 on SCK edges 1–4; exactly 16 SCK rising edges; data_out=10'h181 with data_valid high for one cycle, 69 cycles after the tick.
- Back-to-back frames, model returning 10'h3FF then 10'h000: data_out=10'h3FF then 10'h000; strobes 100 cycles apart; overrun stays 0.
- CHANNEL=0, model returning 10'h2AA: third MOSI bit is 0; data_out=10'h2AA.
- SAMPLE_DIV=60, CLK_DIV=2 (illegal on purpose): second tick lands while busy; overrun goes to 1 and stays; every completed frame still yields a correct data_out.
- rst_n pulsed low during SCK period 8: cs_n=1, sck=0, data_out=10'h000 asynchronously; no data_valid; next frame after release returns the model value correctly.
- Bit-order check, model driving 10'h201: data_out=10'h201 (MSB and LSB are not swapped).
